fpu_issue_ctl: RTL and testbench

Issue controller and scoreboard for the 4-stage FpuFpD pipeline. It accepts decoded FPU operations from decode with a valid/ready handshake, detects hazards, and delays the datapath `opMode` by one cycle so it lines up with FpuFpD's registered operands. It also tracks every in-flight operation and emits writeback strobes aligned to the pipeline's fixed latency. It sits between decode/regfile read and FpuFpD.

---
 rtl/fpu_issue_ctl.sv | 132 +++++++++++++
 tb/tb_fpu_issue_ctl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_issue_ctl.sv
// Issue controller and writeback scoreboard for the 4-stage FpuFpD pipeline.
// Define FPUCTL_SCOREBOARD_EN for per-register hazards; otherwise every op is serialized on busy.
module fpu_issue_ctl #(
  parameter int unsigned LAT_D = 5,
  parameter int unsigned LAT_S = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       issValid,
  output logic       issReady,
  input  logic [7:0] issOpMode,
  input  logic [1:0] issIdMode,
  input  logic [6:0] issRegA,
  input  logic [6:0] issRegB,
  input  logic [6:0] issRegC,
  input  logic       issRdC,
  input  logic       issRdFpul,
  input  logic       issWrFpul,
  input  logic       issWrSr,
  input  logic       flush,
  output logic [7:0] fpuOpMode,
  output logic [1:0] fpuIdMode,
  output logic       wbValid,
  output logic [6:0] wbRegD,
  output logic [1:0] wbModeD,
  output logic       wbSr,
  output logic       wbFpul,
  output logic       busy,
  output logic [2:0] inFlight
);

  localparam logic [7:0] UCMD_FPU_NONE = 8'h00;
  localparam logic [6:0] UREG_ZZR      = 7'h7F;

  logic       r_vld  [LAT_D];
  logic [6:0] r_reg  [LAT_D];
  logic [1:0] r_mode [LAT_D];
  logic       r_sr   [LAT_D];
  logic       r_fpul [LAT_D];
  logic [2:0] r_cnt;
  logic [7:0] r_op;
  logic [1:0] r_id;

  logic w_acc;
  logic w_wb;
  logic w_hazard;

  assign w_acc    = issValid && issReady;
  assign w_wb     = r_vld[LAT_D-1];
  assign issReady = !reset && !flush && !w_hazard;

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      for (int i = 0; i < int'(LAT_D); i++) begin
        r_vld[i]  <= 1'b0;
        r_reg[i]  <= UREG_ZZR;
        r_mode[i] <= 2'd0;
        r_sr[i]   <= 1'b0;
        r_fpul[i] <= 1'b0;
      end
      r_cnt <= 3'd0;
    end else begin
      r_vld[0]  <= w_acc;
      r_reg[0]  <= w_acc ? issRegC : UREG_ZZR;
      r_mode[0] <= w_acc ? issIdMode : 2'd0;
      r_sr[0]   <= w_acc && issWrSr;
      r_fpul[0] <= w_acc && issWrFpul;
      for (int i = 1; i < int'(LAT_D); i++) begin
        r_vld[i]  <= r_vld[i-1];
        r_reg[i]  <= r_reg[i-1];
        r_mode[i] <= r_mode[i-1];
        r_sr[i]   <= r_sr[i-1];
        r_fpul[i] <= r_fpul[i-1];
      end
      r_cnt <= r_cnt + {2'b00, w_acc} - {2'b00, w_wb};
    end
  end

  // w_acc is already low under reset or flush, so the operand-aligned mode falls back to NONE.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_op <= UCMD_FPU_NONE;
      r_id <= 2'd0;
    end else begin
      r_op <= w_acc ? issOpMode : UCMD_FPU_NONE;
      r_id <= w_acc ? issIdMode : 2'd0;
    end
  end

  assign fpuOpMode = r_op;
  assign fpuIdMode = r_id;
  assign wbValid   = w_wb && (r_reg[LAT_D-1] != UREG_ZZR);
  assign wbRegD    = r_reg[LAT_D-1];
  assign wbModeD   = r_mode[LAT_D-1];
  assign wbSr      = r_sr[LAT_S-1];
  assign wbFpul    = r_fpul[LAT_S-1];
  assign inFlight  = r_cnt;
  assign busy      = (r_cnt != 3'd0);

`ifdef FPUCTL_SCOREBOARD_EN
  // A source hits a slot on the destination itself, the destination's pair, or its own pair.
  function automatic logic src_hit(input logic [6:0] s, input logic dbl,
                                   input logic [6:0] d, input logic dpair);
    logic [6:0] s_pair;
    logic [6:0] d_pair;
    s_pair  = s ^ 7'd1;
    d_pair  = d ^ 7'd1;
    src_hit = (s != UREG_ZZR) &&
              ((s == d) || (dpair && (s == d_pair)) || (dbl && (s_pair == d)));
  endfunction

  logic w_dbl;
  assign w_dbl = (issIdMode == 2'd1);

  always_comb begin
    w_hazard = 1'b0;
    for (int i = 0; i < int'(LAT_D); i++) begin
      if (r_vld[i]) begin
        if (src_hit(issRegA, w_dbl, r_reg[i], r_mode[i] == 2'd1)) w_hazard = 1'b1;
        if (src_hit(issRegB, w_dbl, r_reg[i], r_mode[i] == 2'd1)) w_hazard = 1'b1;
        if (issRdC && src_hit(issRegC, w_dbl, r_reg[i], r_mode[i] == 2'd1)) w_hazard = 1'b1;
        if (issRdFpul && r_fpul[i]) w_hazard = 1'b1;
      end
    end
  end
`else
  logic w_unused;
  assign w_unused = ^{issRegA, issRegB, issRdC, issRdFpul};
  assign w_hazard = busy;
`endif

endmodule

// File: tb/tb_fpu_issue_ctl.sv
// Directed bench for fpu_issue_ctl; expectations follow FPUCTL_SCOREBOARD_EN when it is defined.
module tb_fpu_issue_ctl;

  localparam logic [7:0] NONE  = 8'h00;
  localparam logic [7:0] ADD   = 8'h01;
  localparam logic [7:0] MUL   = 8'h03;
  localparam logic [7:0] MAC   = 8'h05;
  localparam logic [7:0] CMP   = 8'h08;
  localparam logic [7:0] CNVSI = 8'h0C;
  localparam logic [7:0] LDSF  = 8'h0D;
  localparam logic [6:0] ZZR   = 7'h7F;

`ifdef FPUCTL_SCOREBOARD_EN
  localparam int IndepWait = 0;
`else
  localparam int IndepWait = 5;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       issValid = 1'b0;
  logic       issReady;
  logic [7:0] issOpMode = 8'h00;
  logic [1:0] issIdMode = 2'd0;
  logic [6:0] issRegA = 7'h7F;
  logic [6:0] issRegB = 7'h7F;
  logic [6:0] issRegC = 7'h7F;
  logic       issRdC = 1'b0;
  logic       issRdFpul = 1'b0;
  logic       issWrFpul = 1'b0;
  logic       issWrSr = 1'b0;
  logic       flush = 1'b0;
  logic [7:0] fpuOpMode;
  logic [1:0] fpuIdMode;
  logic       wbValid;
  logic [6:0] wbRegD;
  logic [1:0] wbModeD;
  logic       wbSr;
  logic       wbFpul;
  logic       busy;
  logic [2:0] inFlight;

  int n_cmp = 0;
  int n_err = 0;
  int n;

  fpu_issue_ctl #(.LAT_D(5), .LAT_S(4)) dut (
    .clock(clock), .reset(reset), .issValid(issValid), .issReady(issReady),
    .issOpMode(issOpMode), .issIdMode(issIdMode), .issRegA(issRegA), .issRegB(issRegB),
    .issRegC(issRegC), .issRdC(issRdC), .issRdFpul(issRdFpul), .issWrFpul(issWrFpul),
    .issWrSr(issWrSr), .flush(flush), .fpuOpMode(fpuOpMode), .fpuIdMode(fpuIdMode),
    .wbValid(wbValid), .wbRegD(wbRegD), .wbModeD(wbModeD), .wbSr(wbSr), .wbFpul(wbFpul),
    .busy(busy), .inFlight(inFlight)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled just after the falling edge.
  task automatic step();
    @(negedge clock);
    #1;
  endtask

  // fl = {rdC, rdFpul, wrFpul, wrSr}
  task automatic drive(input logic [7:0] op, input logic [1:0] id, input logic [6:0] a,
                       input logic [6:0] b, input logic [6:0] c, input logic [3:0] fl);
    issValid  = 1'b1;
    issOpMode = op;
    issIdMode = id;
    issRegA   = a;
    issRegB   = b;
    issRegC   = c;
    {issRdC, issRdFpul, issWrFpul, issWrSr} = fl;
    #1;
  endtask

  // Returns cycles waited before acceptance; leaves the bench one cycle after the accept cycle.
  task automatic wait_accept(output int waited);
    waited = 0;
    while (!issReady && waited < 20) begin
      step();
      waited++;
    end
    step();
    issValid = 1'b0;
    #1;
  endtask

  task automatic do_reset();
    drive(ADD, 2'd0, 7'd1, 7'd2, 7'd3, 4'b0000);
    reset = 1'b1;
    step();
    check_eq("rst_ready", 32'(issReady), 0);
    check_eq("rst_opmode", 32'(fpuOpMode), 32'(NONE));
    check_eq("rst_wbvalid", 32'(wbValid), 0);
    step();
    check_eq("rst_ready2", 32'(issReady), 0);
    check_eq("rst_state", 32'({busy, inFlight, wbSr, wbFpul, fpuIdMode, wbModeD}), 0);
    check_eq("rst_wbregd", 32'(wbRegD), 32'(ZZR));
    reset    = 1'b0;
    issValid = 1'b0;
    step();
    check_eq("rst_release_ready", 32'(issReady), 1);
  endtask

  initial begin
    do_reset();

    // Single op: opMode one cycle after acceptance, writeback five cycles after.
    drive(ADD, 2'd0, 7'd1, 7'd2, 7'd3, 4'b0000);
    wait_accept(n);
    check_eq("single_accept", 32'(n), 0);
    check_eq("single_opmode", 32'(fpuOpMode), 32'(ADD));
    check_eq("single_busy", 32'({busy, inFlight}), 32'({1'b1, 3'd1}));
    step();
    check_eq("single_opmode_once", 32'(fpuOpMode), 32'(NONE));
    step();
    step();
    check_eq("single_wb_early", 32'(wbValid), 0);
    step();
    check_eq("single_wb", 32'({wbValid, wbRegD, wbModeD}), 32'({1'b1, 7'd3, 2'd0}));
    step();
    check_eq("single_wb_once", 32'(wbValid), 0);
    check_eq("single_drain", 32'({busy, inFlight}), 0);

    // RAW on source A.
    do_reset();
    drive(ADD, 2'd0, 7'd1, 7'd2, 7'd3, 4'b0000);
    wait_accept(n);
    drive(MUL, 2'd0, 7'd3, 7'd2, 7'd7, 4'b0000);
    check_eq("raw_stall", 32'(issReady), 0);
    wait_accept(n);
    check_eq("raw_accept", 32'(n), 5);

    // Independent op right behind.
    do_reset();
    drive(ADD, 2'd0, 7'd1, 7'd2, 7'd3, 4'b0000);
    wait_accept(n);
    drive(MUL, 2'd0, 7'd4, 7'd5, 7'd6, 4'b0000);
    wait_accept(n);
    check_eq("indep_accept", 32'(n), 32'(IndepWait));

    // Double destination blocks its pair register.
    do_reset();
    drive(ADD, 2'd1, 7'd8, 7'd10, 7'd4, 4'b0000);
    wait_accept(n);
    drive(MUL, 2'd0, 7'd1, 7'd5, 7'd9, 4'b0000);
    wait_accept(n);
    check_eq("pair_accept", 32'(n), 5);

    // MAC reads C as a source.
    do_reset();
    drive(ADD, 2'd0, 7'd1, 7'd2, 7'd3, 4'b0000);
    wait_accept(n);
    drive(MAC, 2'd0, 7'd1, 7'd2, 7'd3, 4'b1000);
    wait_accept(n);
    check_eq("rdc_accept", 32'(n), 5);

`ifdef FPUCTL_SCOREBOARD_EN
    // Register 6 is outside the pair {4,5}; C without rdC is not a source; ZZR never hazards.
    do_reset();
    drive(ADD, 2'd1, 7'd8, 7'd10, 7'd4, 4'b0000);
    wait_accept(n);
    drive(MUL, 2'd0, 7'd1, 7'd6, 7'd9, 4'b0000);
    wait_accept(n);
    check_eq("pair_outside", 32'(n), 0);
    drive(ADD, 2'd0, 7'd1, 7'd2, 7'd4, 4'b0000);
    wait_accept(n);
    check_eq("no_rdc_no_hazard", 32'(n), 0);
    drive(CMP, 2'd0, 7'd1, 7'd2, ZZR, 4'b0001);
    wait_accept(n);
    drive(ADD, 2'd0, ZZR, ZZR, 7'd11, 4'b0000);
    wait_accept(n);
    check_eq("zzr_no_hazard", 32'(n), 0);
`endif

    // FPUL hazard; SR/FPUL strobes four cycles after acceptance; ZZR destination never writes back.
    do_reset();
    drive(CNVSI, 2'd0, 7'd1, ZZR, ZZR, 4'b0011);
    wait_accept(n);
    drive(LDSF, 2'd0, ZZR, ZZR, 7'd9, 4'b0100);
    for (int k = 1; k <= 5; k++) begin
      check_eq($sformatf("fpul_stall_%0d", k), 32'(issReady), 0);
      check_eq($sformatf("fpul_strobe_%0d", k), 32'({wbFpul, wbSr}),
               (k == 4) ? 32'd3 : 32'd0);
      check_eq($sformatf("fpul_nowb_%0d", k), 32'(wbValid), 0);
      step();
    end
    wait_accept(n);
    check_eq("fpul_accept", 32'(n), 0);

    // Flush drops in-flight ops.
    do_reset();
    drive(ADD, 2'd0, 7'd1, 7'd2, 7'd3, 4'b0000);
    wait_accept(n);
`ifdef FPUCTL_SCOREBOARD_EN
    drive(MUL, 2'd0, 7'd4, 7'd5, 7'd6, 4'b0000);
    wait_accept(n);
`else
    step();
`endif
    drive(ADD, 2'd0, 7'd10, 7'd11, 7'd12, 4'b0000);
    flush = 1'b1;
    #1;
    check_eq("flush_ready", 32'(issReady), 0);
    step();
    flush    = 1'b0;
    issValid = 1'b0;
    #1;
    check_eq("flush_busy", 32'({busy, inFlight}), 0);
    check_eq("flush_opmode", 32'(fpuOpMode), 32'(NONE));
    step();
    step();
    check_eq("flush_nowb_5", 32'(wbValid), 0);
    step();
    check_eq("flush_nowb_6", 32'(wbValid), 0);

    // Reset mid-operation drops the op without writeback.
    do_reset();
    drive(ADD, 2'd0, 7'd1, 7'd2, 7'd3, 4'b0000);
    wait_accept(n);
    do_reset();
    for (int k = 0; k < 3; k++) begin
      check_eq($sformatf("midrst_nowb_%0d", k), 32'(wbValid), 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
